// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported data memory between the CPU MEM stage and a
//   DMA/loader port. Each access is sequenced over MEM_LAT cycles of mem_en_o,
//   followed by one DONE cycle in which the winner sees its completion.
//   The CPU has priority. A starvation counter forces a DMA grant after
//   STARVE_MAX consecutive CPU grants that were made while DMA was waiting.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-low reset
//   cpu_req_i/we/addr/wdata
//                       CPU access, held by the CPU until completion
//   cpu_rdata_o         registered CPU read data
//   cpu_stall_o         high while a CPU request is pending and not completing
//   dma_req_i/we/addr/wdata
//                       DMA access, held by the DMA until dma_ack_o
//   dma_rdata_o         registered DMA read data
//   dma_ack_o           one-cycle DMA completion pulse
//   mem_en_o/we/addr/wdata, mem_rdata_i
//                       memory port; read data is valid on the last ACCESS cycle
//   owner_o             owner of the current or most recent access (0 CPU, 1 DMA)
//   busy_o              arbiter is not idle
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,

    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_ack_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              owner_o,
    output logic              busy_o
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [STV_W-1:0]  starve_cnt;

    logic              dma_win;
    logic              starved;

    assign starved = (starve_cnt == STV_W'(STARVE_MAX));
    assign dma_win = dma_req_i && (!cpu_req_i || starved);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            cpu_rdata_o <= '0;
            dma_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i || dma_req_i) begin
                        // The request is sampled here; later changes on the
                        // requester's port do not affect this access.
                        owner_q <= dma_win ? OWN_DMA : OWN_CPU;
                        we_q    <= dma_win ? dma_we_i    : cpu_we_i;
                        addr_q  <= dma_win ? dma_addr_i  : cpu_addr_i;
                        wdata_q <= dma_win ? dma_wdata_i : cpu_wdata_i;
                        lat_cnt <= LAT_W'(MEM_LAT - 1);
                        // Only CPU grants made while DMA waits count toward
                        // starvation; anything else restarts the count.
                        if (dma_win || !dma_req_i)
                            starve_cnt <= '0;
                        else if (!starved)
                            starve_cnt <= starve_cnt + 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        if (!we_q) begin
                            if (owner_q == OWN_DMA)
                                dma_rdata_o <= mem_rdata_i;
                            else
                                cpu_rdata_o <= mem_rdata_i;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so the async reset
    // drops mem_en_o immediately and an aborted access never reaches DONE.
    assign mem_en_o    = (state == ACCESS);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign owner_o     = owner_q;
    assign busy_o      = (state != IDLE);
    assign dma_ack_o   = (state == DONE) && (owner_q == OWN_DMA);
    // Combinational on cpu_req_i so the hazard unit sees a stall in the same
    // cycle a new CPU request appears.
    assign cpu_stall_o = cpu_req_i && !((state == DONE) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: MEM_LAT=2, STARVE_MAX=4 ----------------
    logic        a_cpu_req, a_cpu_we, a_dma_req, a_dma_we;
    logic [31:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
    logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_cpu_stall, a_dma_ack, a_mem_en, a_mem_we, a_owner, a_busy;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(a_cpu_req), .cpu_we_i(a_cpu_we), .cpu_addr_i(a_cpu_addr),
        .cpu_wdata_i(a_cpu_wdata), .cpu_rdata_o(a_cpu_rdata), .cpu_stall_o(a_cpu_stall),
        .dma_req_i(a_dma_req), .dma_we_i(a_dma_we), .dma_addr_i(a_dma_addr),
        .dma_wdata_i(a_dma_wdata), .dma_rdata_o(a_dma_rdata), .dma_ack_o(a_dma_ack),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata),
        .owner_o(a_owner), .busy_o(a_busy)
    );

    logic [31:0] mem_a [0:63];
    assign a_mem_rdata = mem_a[a_mem_addr[7:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= 32'd0;
            mem_a[2] <= 32'd10;      // 0x08
            mem_a[8] <= 32'h55;      // 0x20
        end else if (a_mem_en && a_mem_we) begin
            mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
        end
    end

    // ---------------- instance B: MEM_LAT=1 ----------------
    logic        b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
    logic [31:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
    logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_cpu_stall, b_dma_ack, b_mem_en, b_mem_we, b_owner, b_busy;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(b_cpu_req), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr),
        .cpu_wdata_i(b_cpu_wdata), .cpu_rdata_o(b_cpu_rdata), .cpu_stall_o(b_cpu_stall),
        .dma_req_i(b_dma_req), .dma_we_i(b_dma_we), .dma_addr_i(b_dma_addr),
        .dma_wdata_i(b_dma_wdata), .dma_rdata_o(b_dma_rdata), .dma_ack_o(b_dma_ack),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
        .owner_o(b_owner), .busy_o(b_busy)
    );

    logic [31:0] mem_b [0:63];
    assign b_mem_rdata = mem_b[b_mem_addr[7:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= 32'd0;
            mem_b[4] <= 32'd29;      // 0x10
        end else if (b_mem_en && b_mem_we) begin
            mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
        end
    end

    logic [9:0] own_v;
    logic [4:0] en_v, st_v, we_v, ack_v, ow_v;
    int         ad_ok, t, acks;

    initial begin
        rst_n = 1'b0;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_dma_req = 0; a_dma_we = 0; a_dma_addr = 0; a_dma_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_en",    a_mem_en,    0);
        chk("rst_busy",  a_busy,      0);
        chk("rst_ack",   a_dma_ack,   0);
        chk("rst_owner", a_owner,     0);
        chk("rst_crd",   a_cpu_rdata, 0);
        chk("rst_drd",   a_dma_rdata, 0);
        chk("rst_addr",  a_mem_addr,  0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: CPU read 0x08
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h08;
        en_v = 0; st_v = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            en_v[k] = a_mem_en; st_v[k] = a_cpu_stall;
        end
        a_cpu_req = 0;
        chk("t1_en",    en_v[3:0],   4'b0110);
        chk("t1_stall", st_v[3:0],   4'b0111);
        chk("t1_rdata", a_cpu_rdata, 32'd10);

        // T2: DMA write 0x14 = 0xDEAD
        @(negedge clk);
        a_dma_req = 1; a_dma_we = 1; a_dma_addr = 32'h14; a_dma_wdata = 32'hDEAD;
        en_v = 0; we_v = 0; ack_v = 0; ad_ok = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            en_v[k] = a_mem_en; we_v[k] = a_mem_we; ack_v[k] = a_dma_ack;
            if (a_mem_en && a_mem_addr != 32'h14) ad_ok = 0;
        end
        a_dma_req = 0; a_dma_we = 0;
        repeat (2) @(negedge clk);
        chk("t2_en",   en_v[3:0],  4'b0110);
        chk("t2_we",   we_v[3:0],  4'b0110);
        chk("t2_ack",  ack_v[3:0], 4'b1000);
        chk("t2_addr", ad_ok,      1);
        chk("t2_mem",  mem_a[5],   32'hDEAD);

        // T3: both requesting continuously
        @(negedge clk);
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h00;
        a_dma_req = 1; a_dma_we = 0; a_dma_addr = 32'h04;
        own_v = 0;
        for (int g = 0; g < 10; g++) begin
            t = 0;
            while (!a_mem_en && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) chk("t3_grant_timeout", 0, 1);
            own_v[g] = a_owner;
            t = 0;
            while (a_busy && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) chk("t3_idle_timeout", 0, 1);
        end
        a_cpu_req = 0; a_dma_req = 0;
        chk("t3_grants", own_v, 10'b1000010000);

        // T4: CPU write 0x0C = 18, request dropped in first ACCESS cycle,
        //     DMA read 0x20 raised at the same moment
        @(negedge clk);
        a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h0C; a_cpu_wdata = 32'd18;
        #1;
        chk("t4_stall0", a_cpu_stall, 1);
        en_v = 0; st_v = 0; ow_v = 0;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk); #1;
            en_v[k-1] = a_mem_en; ow_v[k-1] = a_owner;
            if (k == 1) begin
                a_cpu_req = 0; a_cpu_we = 0;
                a_dma_req = 1; a_dma_we = 0; a_dma_addr = 32'h20;
                #1;
            end
            st_v[k-1] = a_cpu_stall;
        end
        chk("t4_en",    en_v, 5'b10011);
        chk("t4_owner", ow_v, 5'b10000);
        chk("t4_stall", st_v, 5'b00000);
        t = 0;
        while (!a_dma_ack && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) chk("t4_ack_timeout", 0, 1);
        a_dma_req = 0;
        chk("t4_drd", a_dma_rdata, 32'h55);
        chk("t4_mem", mem_a[3],    32'd18);

        // T5: reset in the middle of a DMA ACCESS
        @(negedge clk);
        a_dma_req = 1; a_dma_we = 1; a_dma_addr = 32'h18; a_dma_wdata = 32'h77;
        @(negedge clk); #1;
        chk("t5_pre_en", a_mem_en, 1);
        rst_n = 1'b0; a_dma_req = 0; a_dma_we = 0;
        #1;
        chk("t5_en",   a_mem_en,    0);
        chk("t5_busy", a_busy,      0);
        chk("t5_crd",  a_cpu_rdata, 0);
        chk("t5_drd",  a_dma_rdata, 0);
        acks = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); if (a_dma_ack) acks++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); if (a_dma_ack) acks++;
        end
        chk("t5_noack", acks, 0);
        a_dma_req = 1; a_dma_we = 0; a_dma_addr = 32'h08;
        ack_v = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            ack_v[k] = a_dma_ack;
        end
        a_dma_req = 0;
        chk("t5_ack", ack_v[3:0],  4'b1000);
        chk("t5_drd2", a_dma_rdata, 32'd10);

        // T6: MEM_LAT=1 CPU read 0x10
        @(negedge clk);
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h10;
        en_v = 0; st_v = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            en_v[k] = b_mem_en; st_v[k] = b_cpu_stall;
        end
        b_cpu_req = 0;
        chk("t6_en",    en_v[2:0],   3'b010);
        chk("t6_stall", st_v[2:0],   3'b011);
        chk("t6_rdata", b_cpu_rdata, 32'd29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between the CPU MEM stage and a DMA/loader port.
- Sequences each access over a configurable memory latency.
- Stalls the CPU pipeline through cpu_stall_o; the hazard unit ORs this into its stall.
- CPU has priority; a starvation counter guarantees DMA progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles mem_en_o is held per access (>=1)
STARVE_MAX, 4, consecutive CPU grants with DMA waiting before DMA is forced (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
cpu_req_i  in  1  CPU access request, held until completion
cpu_we_i  in  1  CPU write enable
cpu_addr_i  in  ADDR_W  CPU byte address
cpu_wdata_i  in  DATA_W  CPU write data
cpu_rdata_o  out  DATA_W  CPU read data, registered
cpu_stall_o  out  1  high while CPU request is pending and not completing
dma_req_i  in  1  DMA request, held until dma_ack_o
dma_we_i  in  1  DMA write enable
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_rdata_o  out  DATA_W  DMA read data, registered
dma_ack_o  out  1  one-cycle DMA completion pulse
mem_en_o  out  1  memory enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid on last ACCESS cycle
owner_o  out  1  current owner: 0 = CPU, 1 = DMA
busy_o  out  1  state != IDLE

Behaviour:
Reset (rst_i low, async):
- State IDLE; all outputs 0; both rdata registers 0; starve_cnt 0; latency counter 0.
- mem_en_o falls immediately, even mid-ACCESS; the aborted transaction produces no ack.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- No request: stay.
- Otherwise select the winner and latch owner/we/addr/wdata from it; lat_cnt <= MEM_LAT-1; go to ACCESS.
- Winner is DMA if dma_req_i && (!cpu_req_i || starve_cnt == STARVE_MAX); otherwise CPU.

ACCESS:
- mem_en_o = 1; mem_we_o/addr/wdata driven from the latched registers only. Requester port changes are ignored.
- lat_cnt decrements each cycle.
- When lat_cnt == 0: capture mem_rdata_i into the owner's rdata register (reads only; writes leave it unchanged); go to DONE.

DONE (one cycle):
- Owner DMA: dma_ack_o = 1.
- Owner CPU: cpu_stall_o = 0.
- Next state is always IDLE. There is no same-cycle re-grant.

Timing and outputs:
- cpu_stall_o = cpu_req_i && !(state == DONE && owner == CPU), combinational.
- Request-to-completion latency: MEM_LAT+2 cycles (1 IDLE + MEM_LAT ACCESS + 1 DONE).
- rdata outputs hold their value until the next read completion for the same owner.

starve_cnt (updated in IDLE on grant):
- CPU granted while dma_req_i high: +1, saturating at STARVE_MAX.
- DMA granted, or CPU granted with dma_req_i low: cleared to 0.

Boundary conditions:
- Requester drops its request during ACCESS: the access completes (a write is committed), no ack/stall effect, and read data is still latched.
- Both requests arrive in the same IDLE cycle with starve_cnt < STARVE_MAX: CPU wins; DMA waits in IDLE for the next arbitration.
- MEM_LAT = 1: ACCESS lasts exactly one cycle.
- Request with address/we changing while the requester waits in IDLE: the value sampled at the grant cycle is used.

Test Plan:
1. MEM_LAT=2, mem[0x08]=10, CPU read 0x08: mem_en_o high for 2 cycles; cpu_stall_o high for 3 cycles, then low in the 4th (DONE); cpu_rdata_o=10.
2. DMA write 0x14 data 0xDEAD with CPU idle: mem_we_o and mem_en_o high for 2 cycles with mem_addr_o=0x14; dma_ack_o pulses one cycle in cycle 4; memory word 5 = 0xDEAD.
3. CPU and DMA requesting continuously (each re-requesting immediately after completion), STARVE_MAX=4: grant sequence CPU,CPU,CPU,CPU,DMA repeating; owner_o matches; starve_cnt returns to 0 after each DMA grant.
4. CPU write 0x0C=18, cpu_req_i dropped in the first ACCESS cycle: write still lands in memory; no DMA grant until DONE→IDLE; cpu_stall_o stays 0 after the drop.
5. rst_i pulled low in the middle of a DMA ACCESS: mem_en_o=0 within the same cycle; no dma_ack_o. After release: busy_o=0, rdata registers 0, starve_cnt 0, and a fresh DMA request completes normally.
6. MEM_LAT=1, CPU read of mem[0x10]=29: completes in 3 cycles; cpu_rdata_o=29; mem_en_o high exactly 1 cycle.
